// File: rtl/wb_prog_loader_pkg.sv
// Shared definitions for the TMS1x00 program loader: FSM encodings,
// error codes and the wrapper control-register values.
package wb_prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_FILL,
    S_WRITE,
    S_VERIFY,
    S_RELEASE,
    S_DONE,
    S_ERR
  } state_e;

  typedef enum logic [1:0] {
    M_IDLE,
    M_CYC,
    M_GAP
  } mp_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_VERIFY  = 2'd2;
  localparam logic [1:0] ERR_LEN     = 2'd3;

  // Wrapper control register: bit0 overrides the core, bit1 holds it in reset.
  localparam int          CTRL_OVR_BIT = 0;
  localparam int          CTRL_RST_BIT = 1;
  localparam logic [31:0] CTRL_HOLD    = (32'd1 << CTRL_OVR_BIT) | (32'd1 << CTRL_RST_BIT);
  localparam logic [31:0] CTRL_RUN     = 32'h0;

endpackage

// File: rtl/wb_prog_loader_if.sv
// Wishbone classic bus between the loader (master) and the core wrapper (slave).
interface wb_prog_loader_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;

  modport master (output adr, dat_w, we, cyc, stb, input dat_r, ack);
  modport slave  (input adr, dat_w, we, cyc, stb, output dat_r, ack);
endinterface

// File: rtl/wb_prog_loader_wb_master_port.sv
// Single-transaction Wishbone engine. A request is latched onto the bus and
// held until the first sampled ack; the bus then idles for GAP cycles so the
// responder's lagging ack cannot be mistaken for the next cycle's. o_done
// pulses when the engine is free again (or on timeout, with o_timeout).
module wb_master_port
  import wb_prog_loader_pkg::*;
#(
  parameter int GAP     = 2,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic            i_req,
  input  logic            i_we,
  input  logic [31:0]     i_adr,
  input  logic [31:0]     i_dat,
  output logic            o_done,
  output logic            o_timeout,
  output logic [31:0]     o_rdata,
  wb_prog_loader_if.master wbm
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP + 1);

  mp_state_e   r_mst, w_mnext;
  logic        r_cyc, r_we;
  logic [31:0] r_adr, r_dat, r_rdata;
  logic [TW-1:0] r_tmo;
  logic [GW-1:0] r_gap;
  logic        w_ack_hit, w_tmo_hit, w_gap_end;

  assign w_ack_hit = (r_mst == M_CYC) && wbm.ack;
  assign w_tmo_hit = (r_mst == M_CYC) && !wbm.ack && (r_tmo == TW'(TIMEOUT - 1));
  assign w_gap_end = (r_mst == M_GAP) && (r_gap == GW'(GAP - 1));

  assign o_done    = w_gap_end || w_tmo_hit;
  assign o_timeout = w_tmo_hit;
  assign o_rdata   = r_rdata;

  assign wbm.cyc   = r_cyc;
  assign wbm.stb   = r_cyc;
  assign wbm.we    = r_we;
  assign wbm.adr   = r_adr;
  assign wbm.dat_w = r_dat;

  // Engine state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) r_mst <= M_IDLE;
    else             r_mst <= w_mnext;
  end

  // Engine next state: issue, wait for ack or timeout, then idle gap.
  always_comb begin
    w_mnext = r_mst;
    case (r_mst)
      M_IDLE:  if (i_req) w_mnext = M_CYC;
      M_CYC:   if (w_ack_hit) w_mnext = M_GAP;
               else if (w_tmo_hit) w_mnext = M_IDLE;
      M_GAP:   if (w_gap_end) w_mnext = M_IDLE;
      default: w_mnext = M_IDLE;
    endcase
  end

  // Bus registers, timeout and gap counters; reset drops cyc/stb at once.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_rdata <= '0;
      r_tmo   <= '0;
      r_gap   <= '0;
    end else begin
      case (r_mst)
        M_IDLE: if (i_req) begin
          r_cyc <= 1'b1;
          r_we  <= i_we;
          r_adr <= i_adr;
          r_dat <= i_dat;
          r_tmo <= '0;
        end
        M_CYC: begin
          if (wbm.ack) begin
            r_cyc   <= 1'b0;
            r_rdata <= wbm.dat_r;
            r_gap   <= '0;
          end else if (w_tmo_hit) begin
            r_cyc <= 1'b0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        M_GAP:   r_gap <= r_gap + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/wb_prog_loader.sv
// Boot loader for the wrapped TMS1x00 core: holds the core in reset, streams
// a little-endian byte image into the program RAM window, reads each word
// back to verify it, then releases the core.
module wb_prog_loader
  import wb_prog_loader_pkg::*;
#(
  parameter int          WORDS     = 512,
  parameter logic [31:0] RAM_BASE  = 32'h0001_0000,
  parameter logic [31:0] CTRL_ADDR = 32'h0080_0000,
  parameter int          GAP       = 2,
  parameter int          TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        start_i,
  input  logic [11:0] len_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  wb_prog_loader_if.master wbm,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);
  // One extra bit so the index can reach WORDS after the last word without wrapping.
  localparam int          IDX_W   = $clog2(WORDS) + 1;
  localparam logic [12:0] MAX_LEN = 13'(4 * WORDS);

  state_e           r_state, w_next;
  logic [11:0]      r_len, r_byte_cnt;
  logic [2:0]       r_lane;
  logic [31:0]      r_word;
  logic [IDX_W-1:0] r_word_idx;
  logic             r_busy, r_done, r_err;
  logic [1:0]       r_err_code;

  logic             w_req, w_we, w_mp_done, w_mp_timeout;
  logic [31:0]      w_adr, w_dat, w_mp_rdata, w_ram_adr;
  logic             w_start, w_take, w_last_byte, w_verify_ok, w_set_done, w_set_err;
  logic [1:0]       w_err_code;

  assign w_ram_adr    = RAM_BASE + {{(30 - IDX_W){1'b0}}, r_word_idx, 2'b00};
  assign w_start      = (r_state == S_IDLE) && start_i;
  assign byte_ready_o = (r_state == S_FILL) && (r_lane < 3'd4) && (r_byte_cnt < r_len);
  assign w_take       = byte_ready_o && byte_valid_i;
  assign w_last_byte  = ((r_byte_cnt + 12'd1) == r_len);

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign err_code_o = r_err_code;

  wb_master_port #(.GAP(GAP), .TIMEOUT(TIMEOUT)) u_port (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_n_i(wb_rst_n_i),
    .i_req     (w_req),
    .i_we      (w_we),
    .i_adr     (w_adr),
    .i_dat     (w_dat),
    .o_done    (w_mp_done),
    .o_timeout (w_mp_timeout),
    .o_rdata   (w_mp_rdata),
    .wbm       (wbm)
  );

  // Sequencer state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  // Sequencer: chooses the bus transaction for each phase and the next phase.
  always_comb begin
    w_next      = r_state;
    w_req       = 1'b0;
    w_we        = 1'b0;
    w_adr       = CTRL_ADDR;
    w_dat       = CTRL_HOLD;
    w_verify_ok = 1'b0;
    w_set_done  = 1'b0;
    w_set_err   = 1'b0;
    w_err_code  = ERR_NONE;
    case (r_state)
      S_IDLE: if (w_start) begin
        if ({1'b0, len_i} > MAX_LEN) begin
          w_next = S_ERR; w_set_err = 1'b1; w_err_code = ERR_LEN;
        end else begin
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        w_req = 1'b1; w_we = 1'b1;
        if (w_mp_done) begin
          if (w_mp_timeout) begin
            w_next = S_ERR; w_set_err = 1'b1; w_err_code = ERR_TIMEOUT;
          end else begin
            w_next = (r_len == 12'd0) ? S_RELEASE : S_FILL;
          end
        end
      end
      S_FILL: if (w_take && ((r_lane == 3'd3) || w_last_byte)) w_next = S_WRITE;
      S_WRITE: begin
        w_req = 1'b1; w_we = 1'b1; w_adr = w_ram_adr; w_dat = r_word;
        if (w_mp_done) begin
          if (w_mp_timeout) begin
            w_next = S_ERR; w_set_err = 1'b1; w_err_code = ERR_TIMEOUT;
          end else begin
            w_next = S_VERIFY;
          end
        end
      end
      S_VERIFY: begin
        w_req = 1'b1; w_adr = w_ram_adr; w_dat = r_word;
        if (w_mp_done) begin
          if (w_mp_timeout) begin
            w_next = S_ERR; w_set_err = 1'b1; w_err_code = ERR_TIMEOUT;
          end else if (w_mp_rdata != r_word) begin
            w_next = S_ERR; w_set_err = 1'b1; w_err_code = ERR_VERIFY;
          end else begin
            w_verify_ok = 1'b1;
            w_next      = (r_byte_cnt < r_len) ? S_FILL : S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        w_req = 1'b1; w_we = 1'b1; w_dat = CTRL_RUN;
        if (w_mp_done) begin
          if (w_mp_timeout) begin
            w_next = S_ERR; w_set_err = 1'b1; w_err_code = ERR_TIMEOUT;
          end else begin
            w_next = S_DONE; w_set_done = 1'b1;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Byte packing, word index and sticky status flags.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_len      <= '0;
      r_byte_cnt <= '0;
      r_lane     <= '0;
      r_word     <= '0;
      r_word_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      if (w_start) begin
        r_len      <= len_i;
        r_byte_cnt <= '0;
        r_lane     <= '0;
        r_word     <= '0;
        r_word_idx <= '0;
        r_busy     <= 1'b1;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
      end
      if (w_take) begin
        r_word[{r_lane[1:0], 3'b000} +: 8] <= byte_i;
        r_lane     <= r_lane + 3'd1;
        r_byte_cnt <= r_byte_cnt + 12'd1;
      end
      if (w_verify_ok) begin
        r_word_idx <= r_word_idx + 1'b1;
        r_lane     <= '0;
        r_word     <= '0;
      end
      if (w_set_done) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
      if (w_set_err) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_code;
        r_busy     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_prog_loader.sv
// Bench for wb_prog_loader: a lagged-ack RAM/control responder, a byte source
// with optional random stalls, and a transaction-list model of the boot sequence.
module tb_wb_prog_loader;
  localparam int          WORDS     = 512;
  localparam logic [31:0] RAM_BASE  = 32'h0001_0000;
  localparam logic [31:0] CTRL_ADDR = 32'h0080_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_i = 1'b0;
  logic [11:0] len_i = '0;
  logic [7:0]  byte_i = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, busy, done, err;
  logic [1:0]  err_code;

  int n_assert = 0;
  int n_fail   = 0;

  wb_prog_loader_if bus ();

  always #5 clk = ~clk;

  wb_prog_loader dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .start_i     (start_i),
    .len_i       (len_i),
    .byte_i      (byte_i),
    .byte_valid_i(byte_valid),
    .byte_ready_o(byte_ready),
    .wbm         (bus),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .err_code_o  (err_code)
  );

  // Responder: ack is stb delayed two cycles, so it lingers after stb drops.
  logic s1 = 1'b0, s2 = 1'b0;
  bit   no_ack = 1'b0, corrupt_en = 1'b0;
  logic [31:0] mem [0:WORDS-1];
  logic [8:0]  ridx;
  always @(posedge clk) begin
    s1 <= bus.stb;
    s2 <= s1;
  end
  assign bus.ack = s2 & ~no_ack;
  assign ridx    = bus.adr[10:2];
  always_comb begin
    bus.dat_r = mem[ridx];
    if (corrupt_en && ridx == 9'd3) bus.dat_r[5] = ~bus.dat_r[5];
  end

  // Monitor: logs every completed transaction and a few bus statistics.
  logic        q_we[$];
  logic [31:0] q_adr[$], q_dat[$];
  int          q_len[$];
  int cur_len = 0, cyc_hi = 0, cyc_starts = 0, rdy_cnt = 0, bad_stb = 0;
  logic cyc_d = 1'b0;
  always @(posedge clk) begin
    cyc_d <= bus.cyc;
    if (bus.cyc && !cyc_d) cyc_starts <= cyc_starts + 1;
    if (bus.cyc) cyc_hi <= cyc_hi + 1;
    if (bus.stb !== bus.cyc) bad_stb <= bad_stb + 1;
    if (byte_ready) rdy_cnt <= rdy_cnt + 1;
    if (bus.cyc && bus.stb && bus.ack) begin
      q_we.push_back(bus.we);
      q_adr.push_back(bus.adr);
      q_dat.push_back(bus.we ? bus.dat_w : bus.dat_r);
      q_len.push_back(cur_len + 1);
      cur_len <= 0;
      if (bus.we && bus.adr[16]) mem[bus.adr[10:2]] <= bus.dat_w;
    end else if (bus.cyc) begin
      cur_len <= cur_len + 1;
    end else begin
      cur_len <= 0;
    end
  end

  // Byte source: presents img[fidx] with optional random stalls.
  logic [7:0] img [0:2047];
  int img_len = 0, fidx = 0;
  bit gap_en = 1'b0;
  always @(posedge clk) begin
    if (start_i && !busy)                fidx <= 0;
    else if (byte_valid && byte_ready)   fidx <= fidx + 1;
  end
  always @(negedge clk) begin
    if (fidx < img_len && (!gap_en || $urandom_range(0, 3) != 0)) begin
      byte_valid = 1'b1;
      byte_i     = img[fidx];
    end else begin
      byte_valid = 1'b0;
      byte_i     = 8'($urandom);
    end
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int len, input bit gaps, output int base);
    base    = q_we.size();
    img_len = (len > 2048) ? 2048 : len;
    gap_en  = gaps;
    @(negedge clk);
    len_i   = 12'(len);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c = 0;
    while (busy && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk({tag, " finish"}, 96'(busy), 96'(0));
    repeat (8) @(negedge clk);
  endtask

  // Reference: CTRL=3, then write+read per word (little-endian packing), then CTRL=0.
  task automatic check_log(input string tag, input int base, input int len, input int bad_word);
    logic        e_we[$];
    logic [31:0] e_adr[$], e_dat[$];
    logic [31:0] w, rd;
    int nw, n, got;
    bit stop;
    e_we.push_back(1'b1); e_adr.push_back(CTRL_ADDR); e_dat.push_back(32'h3);
    nw = (len + 3) / 4;
    stop = 1'b0;
    for (int i = 0; i < nw && !stop; i++) begin
      w = 32'h0;
      for (int b = 0; b < 4; b++)
        if (4 * i + b < len) w = w | (32'(img[4 * i + b]) << (8 * b));
      rd = (i == bad_word) ? (w ^ 32'h20) : w;
      e_we.push_back(1'b1); e_adr.push_back(RAM_BASE + 32'(4 * i)); e_dat.push_back(w);
      e_we.push_back(1'b0); e_adr.push_back(RAM_BASE + 32'(4 * i)); e_dat.push_back(rd);
      if (i == bad_word) stop = 1'b1;
    end
    if (!stop) begin
      e_we.push_back(1'b1); e_adr.push_back(CTRL_ADDR); e_dat.push_back(32'h0);
    end
    got = q_we.size() - base;
    chk({tag, " txn count"}, 96'(got), 96'(e_we.size()));
    n = (got < e_we.size()) ? got : e_we.size();
    for (int j = 0; j < n; j++) begin
      chk($sformatf("%s txn%0d", tag, j), {31'b0, q_we[base + j], q_adr[base + j], q_dat[base + j]},
          {31'b0, e_we[j], e_adr[j], e_dat[j]});
      chk($sformatf("%s len%0d", tag, j), 96'(q_len[base + j]), 96'(3));
    end
    chk({tag, " done"}, 96'(done), 96'(bad_word < 0));
    chk({tag, " err"}, 96'(err), 96'(bad_word >= 0));
    chk({tag, " code"}, 96'(err_code), (bad_word >= 0) ? 96'(2) : 96'(0));
    chk({tag, " busy"}, 96'(busy), 96'(0));
  endtask

  initial begin
    int base, s0, h0, r0, c, len;
    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset flags", {89'b0, byte_ready, bus.cyc, bus.stb, bus.we, busy, done, err, err_code},
        96'(0));
    chk("reset adr/dat", {32'b0, bus.adr, bus.dat_w}, 96'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Six fixed bytes
    for (int k = 0; k < 6; k++) img[k] = 8'(8'h11 * (k + 1));
    load(6, 1'b0, base);
    wait_idle("len6", 2000);
    check_log("len6", base, 6, -1);
    chk("len6 stb==cyc", 96'(bad_stb), 96'(0));

    // Empty image: only the two control writes, no byte requests
    r0 = rdy_cnt;
    load(0, 1'b0, base);
    wait_idle("len0", 2000);
    check_log("len0", base, 0, -1);
    chk("len0 ready never", 96'(rdy_cnt - r0), 96'(0));

    // Full RAM with random bytes and stalls; a start while busy is ignored
    for (int k = 0; k < 2048; k++) img[k] = 8'($urandom);
    load(2048, 1'b1, base);
    repeat (20) @(negedge clk);
    len_i = 12'd0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_idle("full", 60000);
    check_log("full", base, 2048, -1);
    if (q_adr.size() >= 3) chk("full last adr", 96'(q_adr[q_adr.size() - 3]), 96'(32'h0001_07FC));

    // Readback corruption of word 3
    for (int k = 0; k < 20; k++) img[k] = 8'($urandom);
    corrupt_en = 1'b1;
    load(20, 1'b0, base);
    wait_idle("corrupt", 3000);
    check_log("corrupt", base, 20, 3);
    corrupt_en = 1'b0;

    // No ack on the HOLD write
    no_ack = 1'b1;
    s0 = cyc_starts; h0 = cyc_hi;
    load(4, 1'b0, base);
    wait_idle("tmo", 600);
    chk("tmo starts", 96'(cyc_starts - s0), 96'(1));
    chk("tmo cyc cycles", 96'(cyc_hi - h0), 96'(255));
    chk("tmo flags", {91'b0, done, err, err_code, bus.cyc}, {91'b0, 1'b0, 1'b1, 2'd1, 1'b0});
    chk("tmo no txn", 96'(q_we.size() - base), 96'(0));
    no_ack = 1'b0;

    // Over-long image
    s0 = cyc_starts;
    load(2049, 1'b0, base);
    chk("len2049 flags", {92'b0, busy, err, err_code}, {92'b0, 1'b0, 1'b1, 2'd3});
    repeat (10) @(negedge clk);
    chk("len2049 no bus", 96'(cyc_starts - s0), 96'(0));

    // Reset during a RAM write, then a fresh load
    for (int k = 0; k < 16; k++) img[k] = 8'($urandom);
    load(16, 1'b0, base);
    c = 0;
    while (!(bus.cyc && bus.we && bus.adr[16]) && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("rst reached write", 96'(c < 500), 96'(1));
    rst_n = 1'b0;
    #1;
    chk("rst async drop", {93'b0, bus.cyc, bus.stb, busy}, 96'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 13; k++) img[k] = 8'($urandom);
    load(13, 1'b1, base);
    wait_idle("reload", 3000);
    check_log("reload", base, 13, -1);

    // A few random lengths
    for (int t = 0; t < 3; t++) begin
      len = $urandom_range(1, 40);
      for (int k = 0; k < len; k++) img[k] = 8'($urandom);
      load(len, 1'($urandom_range(0, 1)), base);
      wait_idle($sformatf("rand%0d", t), 5000);
      check_log($sformatf("rand%0d", t), base, len, -1);
    end
    chk("stb==cyc overall", 96'(bad_stb), 96'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_prog_loader.md
Name: wb_prog_loader

Overview:
- Wishbone classic initiator that boots the wrapped TMS1x00 core: holds the core in reset, streams a byte-serial program image into the core's program RAM window, reads back every word to verify it, then releases the core.
- Sits between a byte source (UART/SPI receiver, valid/ready) and the core wrapper's Wishbone responder port.
- Drives the wrapper's control register (override/reset bits) and its RAM window.

Parameters:
- WORDS, 512, program RAM depth in 32-bit words (9-bit word address).
- RAM_BASE, 32'h0001_0000, RAM window base (bit16 selects RAM).
- CTRL_ADDR, 32'h0080_0000, control register address (bit23 selects control).
- GAP, 2, idle cycles with stb low after every ack; the responder's ack lags by two cycles and stays high that long.
- TIMEOUT, 255, maximum cycles waiting for ack before error.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle start pulse; ignored unless IDLE.
- len_i  in  12  image length in bytes, 0..4*WORDS; latched on start.
- byte_i  in  8  image byte.
- byte_valid_i  in  1  byte_i valid.
- byte_ready_o  out  1  byte accepted when valid&ready.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  write data.
- wbm_we_o  out  1  write enable.
- wbm_cyc_o  out  1  cycle.
- wbm_stb_o  out  1  strobe; always equal to cyc.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  acknowledge.
- busy_o  out  1  high from start accepted to DONE/ERR.
- done_o  out  1  sticky success flag; cleared on start.
- err_o  out  1  sticky error flag; cleared on start.
- err_code_o  out  2  error cause: 1 = timeout, 2 = verify mismatch, 3 = len_i too large.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Bus cycle rules:
  - cyc/stb/adr/dat/we are registered and held stable until the first cycle wbm_ack_i=1 is sampled.
  - cyc/stb drop on the next edge, followed by GAP cycles with cyc=0. Any ack during the gap is ignored.
  - A timeout counter restarts at each cycle start. TIMEOUT cycles without ack -> ERR with code 1, cyc/stb dropped.
- States:
  - IDLE: on start_i, latch len_i, clear flags, set busy_o. If len_i > 4*WORDS -> ERR code 3; else -> HOLD.
  - HOLD: write CTRL_ADDR with data 32'h3 (override + core reset). On ack -> FILL; if len is 0 -> RELEASE.
  - FILL: byte_ready_o=1 while fewer than 4 bytes are packed and bytes remain. Packing is little-endian: byte k of the image goes to word k/4, bits [8*(k%4)+:8]. -> WRITE when 4 bytes are packed, or when the last byte is packed with the unused lanes zero.
  - WRITE: adr = RAM_BASE + 4*word_idx, we=1. On ack -> GAP -> VERIFY.
  - VERIFY: same adr, we=0. Compare wbm_dat_i to the packed word in the ack cycle. Mismatch -> ERR code 2. Match: increment word_idx; more bytes remain -> FILL, else -> RELEASE.
  - RELEASE: write CTRL_ADDR with 32'h0 (release override and reset). On ack -> DONE.
  - DONE: done_o=1, busy_o=0 -> IDLE.
  - ERR: err_o=1, busy_o=0, no further bus cycles -> IDLE. The core is left in reset (HOLD state persists in the wrapper).
- Boundary cases:
  - byte_ready_o=0 outside FILL.
  - byte_valid_i stalls in FILL are held indefinitely; there is no timeout on the byte source.
  - start_i while busy is ignored.
  - Reset asserted mid-cycle: cyc/stb drop asynchronously, and the wrapper is left as-is.
  - len_i = 4*WORDS writes words 0..WORDS-1 exactly; word_idx never wraps.
  - Only in the VERIFY cycle does read data matter.

Decomposition:
- Shared package: state encoding, error codes, CTRL_HOLD=32'h3 / CTRL_RUN=32'h0, bit positions of the override/reset bits.
- One sub-module, wb_master_port: a single-transaction engine (req/we/adr/dat in, done/rdata/timeout out) that owns the GAP and TIMEOUT counters. The top-level FSM sequences it.

Test Plan:
- len=6, bytes 11 22 33 44 55 66, behavioural responder with 2-cycle lagged ack:
  - writes CTRL=3, then RAM 0x10000=0x44332211, read back, then 0x10004=0x00006655, read back, then CTRL=0.
  - done_o=1, err_o=0; stale acks never start or finish a cycle early.
- len=0 -> exactly two bus cycles (CTRL=3, CTRL=0), done_o=1, byte_ready_o never high.
- len=2048, random bytes, random valid gaps -> 512 writes with final adr 0x107FC, all verified, done_o=1.
- Responder corrupts bit 5 of word 3 on readback -> err_o=1, err_code_o=2, no RELEASE write, busy_o=0.
- Responder never acks the HOLD write -> cyc dropped after 255 cycles, err_code_o=1. Also len_i=2049 -> err_code_o=3 with no bus cycles.
- wb_rst_n_i pulsed low during a WRITE with stb high -> cyc/stb/busy 0 immediately. A fresh start then reloads correctly.
